// File: rtl/rate_matrix_streamer.sv
// rate_matrix_streamer
// Stores an N_STOCKS x N_STOCKS matrix of unsigned exchange rates. On a start
// request it streams the entries one per cycle in row-major order to the pivot
// stage. Each beat carries row/column tags and a last-beat flag, and a done
// pulse follows the final beat. Diagonal entries can be skipped.
module rate_matrix_streamer #(
    parameter int WIDTH     = 16,
    parameter int N_STOCKS  = 4,
    parameter int SKIP_DIAG = 1,
    localparam int IW       = $clog2(N_STOCKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_row,
    input  logic [IW-1:0]    wr_col,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             axiov,
    output logic [WIDTH-1:0] axiod,
    output logic [IW-1:0]    axio_row,
    output logic [IW-1:0]    axio_col,
    output logic             axiolast,
    output logic             done
);

    generate
        if (N_STOCKS < 2) begin : g_bad_size
            $error("rate_matrix_streamer: N_STOCKS must be at least 2");
        end
    endgenerate

    localparam logic [IW-1:0] LAST_IDX  = IW'(N_STOCKS - 1);
    localparam logic [IW-1:0] FIRST_COL = (SKIP_DIAG != 0) ? IW'(1) : IW'(0);
    localparam logic [IW-1:0] FINAL_COL = (SKIP_DIAG != 0) ? IW'(N_STOCKS - 2) : IW'(N_STOCKS - 1);

    // LAUNCH is the one cycle between accepting start and presenting the
    // first beat; it keeps STREAM aligned with axiov and DONE_ST aligned with
    // done, so a start during the done pulse is seen outside IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        STREAM  = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] mem [N_STOCKS][N_STOCKS];

    // Position of the next entry to be issued
    logic [IW-1:0] row_cnt;
    logic [IW-1:0] col_cnt;
    logic [IW-1:0] row_cnt_next;
    logic [IW-1:0] col_cnt_next;

    // Next values of the registered outputs
    logic             issue;
    logic             at_final;
    logic [WIDTH-1:0] axiod_next;
    logic [IW-1:0]    axio_row_next;
    logic [IW-1:0]    axio_col_next;
    logic             axiolast_next;
    logic             done_next;

    // Row-major successor of (r, c), hopping over the diagonal when enabled
    function automatic logic [2*IW-1:0] next_pos(input logic [IW-1:0] r,
                                                 input logic [IW-1:0] c);
        logic [IW-1:0] nr;
        logic [IW-1:0] nc;
        nr = r;
        nc = c;
        if (nc == LAST_IDX) begin
            nc = '0;
            nr = nr + IW'(1);
        end else begin
            nc = nc + IW'(1);
        end
        if ((SKIP_DIAG != 0) && (nr == nc)) begin
            if (nc == LAST_IDX) begin
                nc = '0;
                nr = nr + IW'(1);
            end else begin
                nc = nc + IW'(1);
            end
        end
        return {nr, nc};
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: launch on start, stream until the last beat is out, pulse done
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LAUNCH;
            LAUNCH:  next_state = STREAM;
            STREAM:  if (axiolast) next_state = DONE_ST;
            DONE_ST: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output/datapath logic: decide whether a beat is issued at this edge and what it carries
    always_comb begin
        issue        = (state == LAUNCH) || ((state == STREAM) && !axiolast);
        at_final     = (row_cnt == LAST_IDX) && (col_cnt == FINAL_COL);
        row_cnt_next = row_cnt;
        col_cnt_next = col_cnt;
        if ((state == IDLE) && start) begin
            row_cnt_next = '0;
            col_cnt_next = FIRST_COL;
        end else if (issue) begin
            {row_cnt_next, col_cnt_next} = next_pos(row_cnt, col_cnt);
        end
        axiod_next    = issue ? mem[row_cnt][col_cnt] : '0;
        axio_row_next = issue ? row_cnt : '0;
        axio_col_next = issue ? col_cnt : '0;
        axiolast_next = issue && at_final;
        done_next     = (state == STREAM) && axiolast;
    end

    // Entry position counters
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else begin
            row_cnt <= row_cnt_next;
            col_cnt <= col_cnt_next;
        end
    end

    // Matrix storage: writable only while idle so every stream sees a stable snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_STOCKS; i++) begin
                for (int j = 0; j < N_STOCKS; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else if ((state == IDLE) && wr_en) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Registered beat, status and completion outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            axiov    <= 1'b0;
            axiod    <= '0;
            axio_row <= '0;
            axio_col <= '0;
            axiolast <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy     <= issue;
            axiov    <= issue;
            axiod    <= axiod_next;
            axio_row <= axio_row_next;
            axio_col <= axio_col_next;
            axiolast <= axiolast_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_rate_matrix_streamer.sv
// Bench for rate_matrix_streamer: two instances (diagonal skipped / full
// matrix) share all inputs; a per-instance scoreboard queue holds the beats
// expected from the bench's own copy of the matrix.
module tb_rate_matrix_streamer;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int IW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [IW-1:0]    wr_row;
    logic [IW-1:0]    wr_col;
    logic [WIDTH-1:0] wr_data;
    logic             start;

    logic             s_busy, s_axiov, s_axiolast, s_done;
    logic [WIDTH-1:0] s_axiod;
    logic [IW-1:0]    s_axio_row, s_axio_col;
    logic             f_busy, f_axiov, f_axiolast, f_done;
    logic [WIDTH-1:0] f_axiod;
    logic [IW-1:0]    f_axio_row, f_axio_col;

    always #5 clk = ~clk;

    rate_matrix_streamer #(.WIDTH(WIDTH), .N_STOCKS(N), .SKIP_DIAG(1)) u_skip (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start), .busy(s_busy), .axiov(s_axiov),
        .axiod(s_axiod), .axio_row(s_axio_row), .axio_col(s_axio_col),
        .axiolast(s_axiolast), .done(s_done)
    );

    rate_matrix_streamer #(.WIDTH(WIDTH), .N_STOCKS(N), .SKIP_DIAG(0)) u_full (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start), .busy(f_busy), .axiov(f_axiov),
        .axiod(f_axiod), .axio_row(f_axio_row), .axio_col(f_axio_col),
        .axiolast(f_axiolast), .done(f_done)
    );

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [IW-1:0]    r;
        logic [IW-1:0]    c;
        logic             last;
    } beat_t;

    typedef struct {
        logic [IW-1:0]    r;
        logic [IW-1:0]    c;
        logic [WIDTH-1:0] d;
        logic             exp_busy;
        logic             exp_valid;
    } wr_vec_t;

    beat_t            q_s[$];
    beat_t            q_f[$];
    logic [WIDTH-1:0] model [N][N];

    int checks = 0;
    int errors = 0;
    int s_beats, f_beats, s_dones, f_dones, s_busy_cyc, f_busy_cyc;
    logic mon_en = 1'b0;
    logic s_prev_last = 1'b0;
    logic f_prev_last = 1'b0;
    beat_t got_s, exp_s, got_f, exp_f;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            got_s = {s_axiod, s_axio_row, s_axio_col, s_axiolast};
            if (s_axiov) begin
                s_beats++;
                if (q_s.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL skip_unexpected_beat: got %0h expected no beat", got_s);
                end else begin
                    exp_s = q_s.pop_front();
                    check("skip_beat", 32'(got_s), 32'(exp_s));
                end
            end else begin
                check("skip_idle_outputs", 32'(got_s), 32'd0);
            end
            check("skip_busy_vs_valid", 32'(s_busy), 32'(s_axiov));
            check("skip_done_after_last", 32'(s_done), 32'(s_prev_last));
            if (s_busy) s_busy_cyc++;
            if (s_done) s_dones++;
            s_prev_last = s_axiolast;

            got_f = {f_axiod, f_axio_row, f_axio_col, f_axiolast};
            if (f_axiov) begin
                f_beats++;
                if (q_f.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL full_unexpected_beat: got %0h expected no beat", got_f);
                end else begin
                    exp_f = q_f.pop_front();
                    check("full_beat", 32'(got_f), 32'(exp_f));
                end
            end else begin
                check("full_idle_outputs", 32'(got_f), 32'd0);
            end
            check("full_busy_vs_valid", 32'(f_busy), 32'(f_axiov));
            check("full_done_after_last", 32'(f_done), 32'(f_prev_last));
            if (f_busy) f_busy_cyc++;
            if (f_done) f_dones++;
            f_prev_last = f_axiolast;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_expect();
        beat_t b;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                b.d    = model[r][c];
                b.r    = IW'(r);
                b.c    = IW'(c);
                b.last = (r == N - 1) && (c == N - 1);
                q_f.push_back(b);
                if (r != c) begin
                    b.last = (r == N - 1) && (c == N - 2);
                    q_s.push_back(b);
                end
            end
        end
    endtask

    task automatic begin_stream(input logic do_wr, input logic [IW-1:0] r,
                                input logic [IW-1:0] c, input logic [WIDTH-1:0] d);
        s_beats = 0; f_beats = 0; s_dones = 0; f_dones = 0;
        s_busy_cyc = 0; f_busy_cyc = 0;
        if (do_wr) begin
            wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
            model[r][c] = d;
        end
        start = 1'b1;
        push_expect();
        step();
        start = 1'b0;
        wr_en = 1'b0;
        check("no_beat_in_launch_cycle", 32'(s_axiov), 32'd0);
        check("no_busy_in_launch_cycle", 32'(f_busy), 32'd0);
        step();
        check("skip_first_beat_latency", 32'(s_axiov), 32'd1);
        check("full_first_beat_latency", 32'(f_axiov), 32'd1);
    endtask

    task automatic wait_skip_beats(input int n);
        for (int i = 0; i < 64 && s_beats < n; i++) step();
        if (s_beats < n) begin
            checks++;
            errors++;
            $display("FAIL wait_beats_timeout: got %0d beats required %0d", s_beats, n);
        end
    endtask

    task automatic finish_stream();
        int guard;
        guard = 0;
        while (!(s_dones >= 1 && f_dones >= 1) && guard < 80) begin
            step();
            guard++;
        end
        if (guard >= 80) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got dones %0d/%0d required 1/1", s_dones, f_dones);
        end
        repeat (4) step();
        check("skip_beat_count", 32'(s_beats), 32'd12);
        check("full_beat_count", 32'(f_beats), 32'd16);
        check("skip_done_count", 32'(s_dones), 32'd1);
        check("full_done_count", 32'(f_dones), 32'd1);
        check("skip_busy_cycles", 32'(s_busy_cyc), 32'd12);
        check("full_busy_cycles", 32'(f_busy_cyc), 32'd16);
        check("skip_queue_drained", 32'(q_s.size()), 32'd0);
        check("full_queue_drained", 32'(q_f.size()), 32'd0);
    endtask

    initial begin
        wr_vec_t tbl [N*N];
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                tbl[r*N + c] = '{IW'(r), IW'(c), WIDTH'(16*r + c), 1'b0, 1'b0};
                model[r][c] = '0;
            end
        end

        rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; start = 1'b0;

        // Reset and idle outputs
        repeat (2) step();
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_valid", 32'(s_axiov), 32'd0);
        check("rst_data_tags", 32'({s_axiod, s_axio_row, s_axio_col}), 32'd0);
        check("rst_last_done", 32'({s_axiolast, s_done}), 32'd0);
        check("rst_full_outputs", 32'({f_busy, f_axiov, f_axiod, f_axiolast, f_done}), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        // Stream of a freshly cleared matrix
        begin_stream(1'b0, '0, '0, '0);
        finish_stream();

        // Table-driven load while idle
        for (int i = 0; i < N*N; i++) begin
            wr_en = 1'b1; wr_row = tbl[i].r; wr_col = tbl[i].c; wr_data = tbl[i].d;
            model[tbl[i].r][tbl[i].c] = tbl[i].d;
            step();
            wr_en = 1'b0;
            check("load_busy", 32'(s_busy), 32'(tbl[i].exp_busy));
            check("load_valid", 32'(f_axiov), 32'(tbl[i].exp_valid));
        end
        begin_stream(1'b0, '0, '0, '0);
        finish_stream();

        // Write attempted mid-stream is dropped, now and for later streams
        begin_stream(1'b0, '0, '0, '0);
        wait_skip_beats(3);
        wr_en = 1'b1; wr_row = 2'd2; wr_col = 2'd1; wr_data = 16'hBEEF;
        step();
        wr_en = 1'b0;
        finish_stream();
        begin_stream(1'b0, '0, '0, '0);
        finish_stream();

        // Start together with a write in idle: the write is visible in the stream
        begin_stream(1'b1, 2'd0, 2'd1, 16'h1234);
        check("same_cycle_first_data", 32'(s_axiod), 32'h1234);
        check("same_cycle_first_tags", 32'({s_axio_row, s_axio_col}), 32'h1);
        finish_stream();

        // Starts while streaming and during the done pulse are ignored
        begin_stream(1'b0, '0, '0, '0);
        wait_skip_beats(5);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 64 && s_dones < 1; i++) step();
        check("done_cycle_reached", 32'(s_done), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        finish_stream();

        // Reset in the middle of a stream aborts it and clears storage
        begin_stream(1'b0, '0, '0, '0);
        wait_skip_beats(7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_skip_valid", 32'(s_axiov), 32'd0);
        check("abort_skip_busy", 32'(s_busy), 32'd0);
        check("abort_skip_done", 32'(s_done), 32'd0);
        check("abort_full_status", 32'({f_axiov, f_busy, f_done, f_axiolast}), 32'd0);
        q_s.delete();
        q_f.delete();
        s_dones = 0;
        f_dones = 0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) model[r][c] = '0;
        repeat (20) step();
        check("abort_no_skip_done", 32'(s_dones), 32'd0);
        check("abort_no_full_done", 32'(f_dones), 32'd0);
        begin_stream(1'b0, '0, '0, '0);
        finish_stream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
